// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: fixed-latency byte/halfword/word access to a
// little-endian word array, with busywait stall and sign/zero-extended loads.
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_BITS+1:0]   addr_q;
  logic [31:0]            wdata_q;
  logic [3:0]             rd_op_q;
  logic [2:0]             wr_op_q;
  logic [31:0]            read_data_q;

  logic [31:0]            mem_q [DEPTH];

  logic                   req;
  logic                   commit;
  logic [ADDR_BITS-1:0]   idx;
  logic [31:0]            word;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;
  logic [31:0]            load_d;
  logic [3:0]             be;
  logic [31:0]            wlane;
  logic                   unused_addr_hi;

  assign req            = mem_read[3] | mem_write[2];
  assign commit         = (state_q == ACCESS) && (cnt_q == '0);
  assign idx            = addr_q[ADDR_BITS+1:2];
  assign word           = mem_q[idx];
  assign byte_v         = word[8*addr_q[1:0] +: 8];
  assign half_v         = addr_q[1] ? word[31:16] : word[15:0];
  assign read_data      = read_data_q;
  // Address bits above the array wrap and are intentionally ignored.
  assign unused_addr_hi = ^address[31:ADDR_BITS+2];

  // busywait must rise in the same cycle a request appears in IDLE.
  always_comb begin
    busywait = 1'b0;
    case (state_q)
      IDLE:    busywait = req;
      ACCESS:  busywait = 1'b1;
      default: busywait = 1'b0;
    endcase
  end

  always_comb begin
    load_d = '0;
    case (rd_op_q[2:0])
      3'b000:  load_d = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_d = {{16{half_v[15]}}, half_v};
      3'b010:  load_d = word;
      3'b100:  load_d = {24'd0, byte_v};
      3'b101:  load_d = {16'd0, half_v};
      default: load_d = '0;
    endcase
  end

  // Replicate the store data across lanes so the byte enables alone pick placement.
  always_comb begin
    be    = '0;
    wlane = wdata_q;
    if (wr_op_q[2]) begin
      case (wr_op_q[1:0])
        2'b00: begin
          be    = 4'b0001 << addr_q[1:0];
          wlane = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be    = addr_q[1] ? 4'b1100 : 4'b0011;
          wlane = {2{wdata_q[15:0]}};
        end
        2'b10:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_op_q     <= '0;
      wr_op_q     <= '0;
      read_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= address[ADDR_BITS+1:0];
            wdata_q <= write_data;
            rd_op_q <= mem_read;
            wr_op_q <= mem_write;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (rd_op_q[3] && !wr_op_q[2]) read_data_q <= load_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive rst. A pending store is
  // dropped because reset forces state_q out of ACCESS, so commit stays low.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: timing, lane selection, extension,
// aliasing, reset abort and back-to-back handshakes.
module tb_data_mem_responder;

  localparam int LAT  = 4;
  localparam int BUSY = LAT + 1;

  localparam logic [3:0] RD_NONE = 4'b0000;
  localparam logic [3:0] LB      = 4'b1000;
  localparam logic [3:0] LH      = 4'b1001;
  localparam logic [3:0] LW      = 4'b1010;
  localparam logic [3:0] LBU     = 4'b1100;
  localparam logic [3:0] LHU     = 4'b1101;
  localparam logic [3:0] LBAD    = 4'b1011;
  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] SB      = 3'b100;
  localparam logic [2:0] SH      = 3'b101;
  localparam logic [2:0] SW      = 3'b110;
  localparam logic [2:0] SBAD    = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;

  int          checks = 0;
  int          errors = 0;
  int          busy_n;
  logic [31:0] rd_done;

  data_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busywait   (busywait)
  );

  always #5 clk = ~clk;

  // Driver: called at posedge+1 in IDLE. Holds the request through DONE like a
  // stalled pipeline, records busy-cycle count and read_data seen in DONE.
  task automatic do_txn(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n          = 0;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wd;
    @(negedge clk);
    while (busywait === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    busy_n  = n;
    rd_done = read_data;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout addr=%h busywait never dropped", addr);
    end
    @(posedge clk);
    #1;
    mem_read   = RD_NONE;
    mem_write  = WR_NONE;
    address    = '0;
    write_data = '0;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    mem_read   = RD_NONE;
    mem_write  = WR_NONE;
    address    = '0;
    write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      errors++;
      $display("FAIL reset_busywait got=%b exp=0", busywait);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_read_data got=%h exp=00000000", read_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word;
    do_txn(RD_NONE, SW, 32'h10, 32'h8badf00d);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL sw_busy_cycles got=%0d exp=%0d", busy_n, BUSY);
    end
    do_txn(LW, WR_NONE, 32'h10, 32'h0);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL lw_busy_cycles got=%0d exp=%0d", busy_n, BUSY);
    end
    checks++;
    if (rd_done !== 32'h8BADF00D) begin
      errors++;
      $display("FAIL lw_word got=%h exp=8badf00d", rd_done);
    end
  endtask

  task automatic test_byte;
    do_txn(RD_NONE, SB, 32'h13, 32'h12345680);
    do_txn(LB, WR_NONE, 32'h13, 32'h0);
    checks++;
    if (rd_done !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_sign got=%h exp=ffffff80", rd_done);
    end
    do_txn(LBU, WR_NONE, 32'h13, 32'h0);
    checks++;
    if (rd_done !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_zero got=%h exp=00000080", rd_done);
    end
    do_txn(LW, WR_NONE, 32'h10, 32'h0);
    checks++;
    if (rd_done !== 32'h80ADF00D) begin
      errors++;
      $display("FAIL sb_preserve got=%h exp=80adf00d", rd_done);
    end
  endtask

  task automatic test_half;
    do_txn(RD_NONE, SW, 32'h20, 32'hCAFEBABE);
    do_txn(RD_NONE, SH, 32'h22, 32'hABCD1234);
    do_txn(LH, WR_NONE, 32'h22, 32'h0);
    checks++;
    if (rd_done !== 32'h00001234) begin
      errors++;
      $display("FAIL lh_upper got=%h exp=00001234", rd_done);
    end
    do_txn(LH, WR_NONE, 32'h23, 32'h0);
    checks++;
    if (rd_done !== 32'h00001234) begin
      errors++;
      $display("FAIL lh_a0_ignored got=%h exp=00001234", rd_done);
    end
    do_txn(LW, WR_NONE, 32'h20, 32'h0);
    checks++;
    if (rd_done !== 32'h1234BABE) begin
      errors++;
      $display("FAIL sh_preserve got=%h exp=1234babe", rd_done);
    end
    do_txn(RD_NONE, SH, 32'h20, 32'h00009000);
    do_txn(LHU, WR_NONE, 32'h20, 32'h0);
    checks++;
    if (rd_done !== 32'h00009000) begin
      errors++;
      $display("FAIL lhu_zero got=%h exp=00009000", rd_done);
    end
    do_txn(LH, WR_NONE, 32'h20, 32'h0);
    checks++;
    if (rd_done !== 32'hFFFF9000) begin
      errors++;
      $display("FAIL lh_sign got=%h exp=ffff9000", rd_done);
    end
    do_txn(LW, WR_NONE, 32'h20, 32'h0);
    checks++;
    if (rd_done !== 32'h12349000) begin
      errors++;
      $display("FAIL sh_low_word got=%h exp=12349000", rd_done);
    end
  endtask

  task automatic test_alias;
    do_txn(LW, WR_NONE, 32'h1010, 32'h0);
    checks++;
    if (rd_done !== 32'h80ADF00D) begin
      errors++;
      $display("FAIL alias_load got=%h exp=80adf00d", rd_done);
    end
    do_txn(RD_NONE, SB, 32'hFFFF_F011, 32'h00000077);
    do_txn(LW, WR_NONE, 32'h10, 32'h0);
    checks++;
    if (rd_done !== 32'h80AD770D) begin
      errors++;
      $display("FAIL alias_store got=%h exp=80ad770d", rd_done);
    end
  endtask

  task automatic test_undefined;
    do_txn(LBAD, WR_NONE, 32'h10, 32'h0);
    checks++;
    if (rd_done !== 32'h0) begin
      errors++;
      $display("FAIL bad_read_funct3 got=%h exp=00000000", rd_done);
    end
    do_txn(RD_NONE, SBAD, 32'h10, 32'hFFFFFFFF);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL bad_write_busy got=%0d exp=%0d", busy_n, BUSY);
    end
    checks++;
    if (rd_done !== 32'h0) begin
      errors++;
      $display("FAIL store_keeps_read_data got=%h exp=00000000", rd_done);
    end
    do_txn(LW, WR_NONE, 32'h10, 32'h0);
    checks++;
    if (rd_done !== 32'h80AD770D) begin
      errors++;
      $display("FAIL bad_write_no_change got=%h exp=80ad770d", rd_done);
    end
  endtask

  task automatic test_read_and_write;
    do_txn(LW, SW, 32'h30, 32'h55AA55AA);
    checks++;
    if (rd_done !== 32'h80AD770D) begin
      errors++;
      $display("FAIL rw_read_data_held got=%h exp=80ad770d", rd_done);
    end
    do_txn(LW, WR_NONE, 32'h30, 32'h0);
    checks++;
    if (rd_done !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL rw_write_done got=%h exp=55aa55aa", rd_done);
    end
  endtask

  task automatic test_reset_mid_access;
    do_txn(RD_NONE, SW, 32'h40, 32'h11223344);
    do_txn(LW, WR_NONE, 32'h40, 32'h0);
    checks++;
    if (rd_done !== 32'h11223344) begin
      errors++;
      $display("FAIL pre_abort_load got=%h exp=11223344", rd_done);
    end
    mem_read   = RD_NONE;
    mem_write  = SW;
    address    = 32'h40;
    write_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    mem_write  = WR_NONE;
    address    = '0;
    write_data = '0;
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      errors++;
      $display("FAIL abort_busywait got=%b exp=0", busywait);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_read_data got=%h exp=00000000", read_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_txn(LW, WR_NONE, 32'h40, 32'h0);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL post_abort_busy got=%0d exp=%0d", busy_n, BUSY);
    end
    checks++;
    if (rd_done !== 32'h11223344) begin
      errors++;
      $display("FAIL abort_no_commit got=%h exp=11223344", rd_done);
    end
  endtask

  task automatic test_back_to_back;
    do_txn(RD_NONE, SW, 32'h50, 32'h0);
    do_txn(RD_NONE, SB, 32'h51, 32'h0000005A);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL b2b_first_busy got=%0d exp=%0d", busy_n, BUSY);
    end
    do_txn(LBU, WR_NONE, 32'h51, 32'h0);
    checks++;
    if (busy_n !== BUSY) begin
      errors++;
      $display("FAIL b2b_second_busy got=%0d exp=%0d", busy_n, BUSY);
    end
    checks++;
    if (rd_done !== 32'h0000005A) begin
      errors++;
      $display("FAIL b2b_lbu got=%h exp=0000005a", rd_done);
    end
    @(negedge clk);
    checks++;
    if (busywait !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_retrigger got=%b exp=0", busywait);
    end
    @(posedge clk);
    #1;
    do_txn(LW, WR_NONE, 32'h50, 32'h0);
    checks++;
    if (rd_done !== 32'h00005A00) begin
      errors++;
      $display("FAIL b2b_single_store got=%h exp=00005a00", rd_done);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_alias();
    test_undefined();
    test_read_and_write();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
